// File: rtl/shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// shared_mem_arbiter
//
// Shares one unified 256 x 32-bit memory between the CPU instruction-fetch
// port and the CPU data port. Contention is resolved round-robin via a
// last-grant flag; each transaction walks IDLE -> SERVE_x -> DONE_x -> IDLE.
//
// Ports
//   CLK, RESET                      clock, asynchronous active-high reset
//   I_READ, I_ADDRESS[9:0]          instruction fetch request / byte address
//   I_READDATA[31:0], I_BUSYWAIT    fetched word (registered) / port stall
//   D_READ, D_WRITE                 data read / write request
//   D_ADDRESS[7:0], D_WRITEDATA     data byte address / byte to write
//   D_READDATA[7:0], D_BUSYWAIT     read byte (registered) / port stall
//   M_READ, M_WRITE                 memory request (registered)
//   M_ADDRESS[7:0]                  memory word index (registered)
//   M_WRITEDATA[31:0], M_BYTEEN     write data and lane enables (registered)
//   M_READDATA[31:0], M_BUSYWAIT    memory read data / memory stall
// -----------------------------------------------------------------------------
module shared_mem_arbiter #(
    parameter logic [7:0] DATA_BASE = 8'd192
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        I_READ,
    input  logic [9:0]  I_ADDRESS,
    output logic [31:0] I_READDATA,
    output logic        I_BUSYWAIT,
    input  logic        D_READ,
    input  logic        D_WRITE,
    input  logic [7:0]  D_ADDRESS,
    input  logic [7:0]  D_WRITEDATA,
    output logic [7:0]  D_READDATA,
    output logic        D_BUSYWAIT,
    output logic        M_READ,
    output logic        M_WRITE,
    output logic [7:0]  M_ADDRESS,
    output logic [31:0] M_WRITEDATA,
    output logic [3:0]  M_BYTEEN,
    input  logic [31:0] M_READDATA,
    input  logic        M_BUSYWAIT
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SERVE_I = 3'd1;
    localparam logic [2:0] ST_SERVE_D = 3'd2;
    localparam logic [2:0] ST_DONE_I  = 3'd3;
    localparam logic [2:0] ST_DONE_D  = 3'd4;

    logic [2:0]  r_state;
    logic        r_last_d;      // 1: data port was granted most recently
    logic [1:0]  r_lane;        // byte lane of the latched data access
    logic        r_m_read;
    logic        r_m_write;
    logic [7:0]  r_m_address;
    logic [31:0] r_m_writedata;
    logic [3:0]  r_m_byteen;
    logic [31:0] r_i_readdata;
    logic [7:0]  r_d_readdata;

    logic        w_d_req;
    logic        w_grant_i;
    logic        w_grant_d;
    logic [7:0]  w_d_word;
    logic        w_unused_addr_bits;

    // Word address bits [1:0] of the fetch address carry no information.
    assign w_unused_addr_bits = ^I_ADDRESS[1:0];

    // Picks one byte lane out of a memory word.
    function automatic logic [7:0] fn_select_byte(input logic [31:0] word,
                                                  input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Round-robin grant decision used while IDLE; a tie goes to the port
    // opposite the last grant.
    always_comb begin
        w_d_req   = D_READ | D_WRITE;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        w_d_word  = DATA_BASE + {2'b00, D_ADDRESS[7:2]};
        if (I_READ && w_d_req) begin
            w_grant_i = r_last_d;
            w_grant_d = ~r_last_d;
        end else begin
            w_grant_i = I_READ;
            w_grant_d = w_d_req;
        end
    end

    // Arbitration FSM, memory request registers and captured read data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_last_d      <= 1'b1;
            r_lane        <= 2'b00;
            r_m_read      <= 1'b0;
            r_m_write     <= 1'b0;
            r_m_address   <= 8'h00;
            r_m_writedata <= 32'h0000_0000;
            r_m_byteen    <= 4'b0000;
            r_i_readdata  <= 32'h0000_0000;
            r_d_readdata  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_i) begin
                        r_state     <= ST_SERVE_I;
                        r_last_d    <= 1'b0;
                        r_lane      <= 2'b00;
                        r_m_address <= I_ADDRESS[9:2];
                        r_m_read    <= 1'b1;
                        r_m_write   <= 1'b0;
                        r_m_byteen  <= 4'b1111;
                    end else if (w_grant_d) begin
                        r_state     <= ST_SERVE_D;
                        r_last_d    <= 1'b1;
                        r_lane      <= D_ADDRESS[1:0];
                        r_m_address <= w_d_word;
                        // Read and write together resolve to a write.
                        if (D_WRITE) begin
                            r_m_read      <= 1'b0;
                            r_m_write     <= 1'b1;
                            r_m_writedata <= {4{D_WRITEDATA}};
                            r_m_byteen    <= 4'b0001 << D_ADDRESS[1:0];
                        end else begin
                            r_m_read   <= 1'b1;
                            r_m_write  <= 1'b0;
                            r_m_byteen <= 4'b1111;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SERVE_I: begin
                    // Completes even if the requester has dropped I_READ.
                    if (!M_BUSYWAIT) begin
                        r_i_readdata <= M_READDATA;
                        r_m_read     <= 1'b0;
                        r_m_write    <= 1'b0;
                        r_state      <= ST_DONE_I;
                    end else begin
                        r_state <= ST_SERVE_I;
                    end
                end
                ST_SERVE_D: begin
                    if (!M_BUSYWAIT) begin
                        // Writes leave the held read byte untouched.
                        if (r_m_read) begin
                            r_d_readdata <= fn_select_byte(M_READDATA, r_lane);
                        end else begin
                            r_d_readdata <= r_d_readdata;
                        end
                        r_m_read  <= 1'b0;
                        r_m_write <= 1'b0;
                        r_state   <= ST_DONE_D;
                    end else begin
                        r_state <= ST_SERVE_D;
                    end
                end
                ST_DONE_I: r_state <= ST_IDLE;
                ST_DONE_D: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Stalls rise with the request and drop only in the port's DONE cycle.
    assign I_BUSYWAIT  = I_READ & (r_state != ST_DONE_I);
    assign D_BUSYWAIT  = (D_READ | D_WRITE) & (r_state != ST_DONE_D);

    assign I_READDATA  = r_i_readdata;
    assign D_READDATA  = r_d_readdata;
    assign M_READ      = r_m_read;
    assign M_WRITE     = r_m_write;
    assign M_ADDRESS   = r_m_address;
    assign M_WRITEDATA = r_m_writedata;
    assign M_BYTEEN    = r_m_byteen;

endmodule
